// File: rtl/pc_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit_pkg
// Description : Shared definitions for the PC redirect unit. It holds the
//               control-state encoding {RUN, STALL, FLUSH}, the default reset
//               PC and the instruction size used for sequential fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_redirect_unit_pkg;

    // Control-state encoding, explicit 2-bit width
    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_stall = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam logic [31:0] c_instr_size       = 32'd4;

    // Width of the flush down-counter; it covers FLUSH_CYCLES values 1..7
    localparam int c_flush_cnt_w = 3;

    // Force a branch target onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : pc_redirect_unit_pkg
`default_nettype wire

// File: rtl/pc_flush_timer.sv
`default_nettype none
// ============================================================================
// Module      : pc_flush_timer
// Description : Loadable down-counter that times the pipeline flush window
//               after an accepted redirect.
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset
//   i_load     in  : redirect accepted this edge, so reload to FLUSH_CYCLES
//   o_active   out : registered, high for the FLUSH_CYCLES cycles after a load
//   o_first    out : registered, high in the first cycle of a window
//   o_expiring out : counter is 1, so the window closes at the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module pc_flush_timer
    import pc_redirect_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_active,
    output logic o_first,
    output logic o_expiring
);

    localparam logic [c_flush_cnt_w-1:0] c_load_val = c_flush_cnt_w'(FLUSH_CYCLES);

    logic [c_flush_cnt_w-1:0] r_cnt;
    logic [c_flush_cnt_w-1:0] w_cnt_next;
    logic                     r_active;
    logic                     r_first;

    // A reload always wins, so a back-to-back redirect restarts the window
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = c_load_val;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            // Flag flops track the next count so the flush outputs come
            // straight from registers.
            r_active <= (w_cnt_next != '0);
            r_first  <= i_load;
        end
    end

    assign o_active   = r_active;
    assign o_first    = r_first;
    assign o_expiring = (r_cnt == c_flush_cnt_w'(1));

endmodule : pc_flush_timer
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Owns the fetch PC. It applies branch redirects from EX,
//               honours hazard stalls and drives the IF/ID and ID/EX flushes
//               that cover wrong-path slots.
//   Clk, Rst           : clock and synchronous active-high reset
//   PCSrc, PCNew       : redirect request and redirect target
//   Stall              : hold the PC for the hazard unit
//   InstrAddr, PCPlus4 : fetch address (registered) and fetch address + 4
//   PCWrite            : the PC loads or advances this cycle
//   FlushIFID/IDEX     : registered pipeline-register clears
//   Misaligned         : sticky flag for a target with nonzero low bits
//   RedirectCount      : count of accepted redirects, wraps modulo 2^CNT_W
// Configuration macro : BRANCH_DELAY_SLOT_EN. When it is defined, the first
//               cycle of each window does not flush IF/ID, because the slot
//               after the branch is architectural.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = c_reset_pc_default,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PCSrc,
    input  logic [31:0]      PCNew,
    input  logic             Stall,
    output logic [31:0]      InstrAddr,
    output logic [31:0]      PCPlus4,
    output logic             PCWrite,
    output logic             FlushIFID,
    output logic             FlushIDEX,
    output logic             Misaligned,
    output logic [CNT_W-1:0] RedirectCount
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic c_delay_slot = 1'b1;
`else
    localparam logic c_delay_slot = 1'b0;
`endif

    logic [31:0]      r_pc;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_redirect_count;
    logic             w_flush_active;
    logic             w_flush_first;
    logic             w_flush_expiring;

    pc_flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk        (Clk),
        .rst        (Rst),
        .i_load     (PCSrc),
        .o_active   (w_flush_active),
        .o_first    (w_flush_first),
        .o_expiring (w_flush_expiring)
    );

    // A redirect overrides a stall, because the stalled instruction is on
    // the wrong path anyway.
    always_comb begin
        w_state_next = r_state;
        if (PCSrc) begin
            w_state_next = c_st_flush;
        end else if (r_state == c_st_flush) begin
            if (w_flush_expiring) begin
                w_state_next = Stall ? c_st_stall : c_st_run;
            end
        end else begin
            w_state_next = Stall ? c_st_stall : c_st_run;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc             <= RESET_PC;
            r_state          <= c_st_run;
            r_misaligned     <= 1'b0;
            r_redirect_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (PCSrc) begin
                r_pc             <= align_word(PCNew);
                r_redirect_count <= r_redirect_count + CNT_W'(1);
                if (PCNew[1:0] != 2'b00) begin
                    r_misaligned <= 1'b1;
                end
            end else if (!Stall) begin
                r_pc <= r_pc + c_instr_size;
            end
        end
    end

    assign InstrAddr     = r_pc;
    assign PCPlus4       = r_pc + c_instr_size;
    assign PCWrite       = PCSrc | ~Stall;
    assign FlushIDEX     = w_flush_active;
    assign FlushIFID     = w_flush_active & ~(w_flush_first & c_delay_slot);
    assign Misaligned    = r_misaligned;
    assign RedirectCount = r_redirect_count;

endmodule : pc_redirect_unit
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Self-checking bench for pc_redirect_unit. It runs directed
//               scenarios and then a random phase against a reference model
//               built on edge indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;
    localparam int          CNT_W        = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             PCSrc;
    logic [31:0]      PCNew;
    logic             Stall;
    logic [31:0]      InstrAddr;
    logic [31:0]      PCPlus4;
    logic             PCWrite;
    logic             FlushIFID;
    logic             FlushIDEX;
    logic             Misaligned;
    logic [CNT_W-1:0] RedirectCount;

    pc_redirect_unit #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .PCSrc         (PCSrc),
        .PCNew         (PCNew),
        .Stall         (Stall),
        .InstrAddr     (InstrAddr),
        .PCPlus4       (PCPlus4),
        .PCWrite       (PCWrite),
        .FlushIFID     (FlushIFID),
        .FlushIDEX     (FlushIDEX),
        .Misaligned    (Misaligned),
        .RedirectCount (RedirectCount)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state. The flush window is derived from the index of
    // the edge that accepted the last redirect.
    logic [31:0]      m_pc;
    logic [CNT_W-1:0] m_cnt;
    logic             m_mis;
    int               m_edge;
    int               m_last;
    bit               m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic src,
                              input logic [31:0] nw, input logic st);
        m_edge++;
        if (rst) begin
            m_pc    = RESET_PC;
            m_cnt   = '0;
            m_mis   = 1'b0;
            m_valid = 1'b0;
        end else if (src) begin
            m_pc    = nw & 32'hFFFF_FFFC;
            m_cnt   = m_cnt + 1;
            m_mis   = m_mis | (nw[1:0] != 2'b00);
            m_last  = m_edge;
            m_valid = 1'b1;
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic rst, input logic src,
                        input logic [31:0] nw, input logic st);
        bit f_idex;
        bit f_ifid;
        @(negedge Clk);
        Rst   = rst;
        PCSrc = src;
        PCNew = nw;
        Stall = st;
        #1;
        if (!rst) begin
            chk("pcwrite", {31'd0, PCWrite}, {31'd0, src | ~st});
            chk("pcplus4", PCPlus4, m_pc + 32'd4);
        end
        @(posedge Clk);
        model_edge(rst, src, nw, st);
        #1;
        f_idex = m_valid && ((m_edge - m_last) < FLUSH_CYCLES);
`ifdef BRANCH_DELAY_SLOT_EN
        f_ifid = f_idex && (m_edge != m_last);
`else
        f_ifid = f_idex;
`endif
        chk("instraddr", InstrAddr, m_pc);
        chk("flushidex", {31'd0, FlushIDEX}, {31'd0, f_idex});
        chk("flushifid", {31'd0, FlushIFID}, {31'd0, f_ifid});
        chk("misaligned", {31'd0, Misaligned}, {31'd0, m_mis});
        chk("redircnt", {16'd0, RedirectCount}, {16'd0, m_cnt});
    endtask

    initial begin
        Rst = 1'b1; PCSrc = 1'b0; PCNew = '0; Stall = 1'b0;
        m_pc = RESET_PC; m_cnt = '0; m_mis = 1'b0;
        m_edge = 0; m_last = 0; m_valid = 1'b0;

        // Reset, then three idle cycles: 0, 4, 8, 12
        step(1, 0, 0, 0);
        chk("rst_addr", InstrAddr, 32'h0);
        repeat (3) step(0, 0, 0, 0);
        chk("idle_addr", InstrAddr, 32'd12);

        // Redirect to 0x100 taken at PC=8, with a two-cycle flush
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0100, 0);
        chk("redir_addr", InstrAddr, 32'h100);
        chk("redir_flush", {31'd0, FlushIDEX}, 32'd1);
        step(0, 0, 0, 0);
        chk("redir_next", InstrAddr, 32'h104);
        step(0, 0, 0, 0);
        chk("flush_end", {31'd0, FlushIDEX}, 32'd0);

        // Stall for three cycles at 0x20
        step(0, 1, 32'h0000_0020, 0);
        repeat (3) step(0, 0, 0, 1);
        chk("stall_hold", InstrAddr, 32'h20);
        step(0, 0, 0, 0);
        chk("stall_resume", InstrAddr, 32'h24);

        // A redirect wins over a stall, then a back-to-back redirect restarts the window
        step(1, 0, 0, 0);
        step(0, 1, 32'h0000_0040, 1);
        chk("redir_vs_stall", InstrAddr, 32'h40);
        step(0, 1, 32'h0000_0080, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("double_count", {16'd0, RedirectCount}, 32'd2);

        // A misaligned target is word-aligned and sets the sticky flag
        step(0, 1, 32'h0000_0203, 0);
        chk("misal_addr", InstrAddr, 32'h200);
        repeat (4) step(0, 0, 0, 0);
        chk("misal_sticky", {31'd0, Misaligned}, 32'd1);

        // Reset in the middle of a flush window
        step(0, 1, 32'h0000_0300, 0);
        step(1, 0, 0, 0);
        chk("midflush_rst", {31'd0, FlushIDEX}, 32'd0);
        chk("midflush_mis", {31'd0, Misaligned}, 32'd0);

        // The PC wraps from 0xFFFF_FFFC to 0
        step(0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0);
        chk("wrap_addr", InstrAddr, 32'h0);

        // Random phase
        for (int i = 0; i < 500; i++) begin
            logic [31:0] nw;
            nw = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), nw,
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_pc_redirect_unit
`default_nettype wire
